// File: rtl/fp_mult_stream_pkg.sv
// Shared definitions for the FP32 multiplier streaming wrapper.
// Holds the default widths, the rounding-mode encoding and the FIFO entry sizing.
package fp_mult_stream_pkg;

  localparam int FP_WIDTH = 32;
  localparam int OP_DEPTH = 4;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rnd_mode_e;

  // One buffered operation is {a, b, rnd}.
  function automatic int op_entry_width(input int width);
    return (2 * width) + 2;
  endfunction

endpackage

// File: rtl/fp_mult_stream_if.sv
// Operand, core and result buses of fp_mult_stream.
// The slave modport is the block's view; the master modport drives it.
interface fp_mult_stream_if
  import fp_mult_stream_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = OP_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_rnd;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [1:0]       mul_rnd;
  logic [WIDTH-1:0] mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  flush, in_valid, in_a, in_b, in_rnd, mul_result, out_ready,
    output in_ready, mul_a, mul_b, mul_rnd, out_valid, out_result, fifo_count
  );

  modport master (
    output flush, in_valid, in_a, in_b, in_rnd, mul_result, out_ready,
    input  in_ready, mul_a, mul_b, mul_rnd, out_valid, out_result, fifo_count
  );

endinterface

// File: rtl/fp_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries of {a, b, rnd}, head visible combinationally.
// A push while full is dropped even if a pop happens in the same cycle.
module fp_operand_fifo
  import fp_mult_stream_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = OP_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              push,
  input  logic                              pop,
  input  logic [op_entry_width(WIDTH)-1:0]  wr_data,
  output logic [op_entry_width(WIDTH)-1:0]  rd_data,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full,
  output logic                              empty
);
  localparam int DW    = op_entry_width(WIDTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign push_s  = push && !full;
  assign pop_s   = pop && !empty;
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; power-of-two depth makes pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/fp_mult_stream.sv
// Streaming wrapper around the combinational FP32 multiplier core: operand FIFO,
// a registered operand stage feeding the core, and a registered result stage.
module fp_mult_stream
  import fp_mult_stream_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = OP_DEPTH
) (
  input logic             clk,
  input logic             rst,
  fp_mult_stream_if.slave io
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DW    = op_entry_width(WIDTH);

  logic [DW-1:0]    wr_data_s;
  logic [DW-1:0]    rd_data_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;
  logic [WIDTH-1:0] head_a_s;
  logic [WIDTH-1:0] head_b_s;
  logic [1:0]       head_rnd_s;
  logic             s2_adv_s;
  logic             s1_free_s;
  logic             pop_s;

  logic             s1_valid_r;
  logic [WIDTH-1:0] mul_a_r;
  logic [WIDTH-1:0] mul_b_r;
  logic [1:0]       mul_rnd_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;

  assign wr_data_s = {io.in_a, io.in_b, io.in_rnd};
  assign {head_a_s, head_b_s, head_rnd_s} = rd_data_s;

  fp_operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (io.flush),
    .push    (io.in_valid),
    .pop     (pop_s),
    .wr_data (wr_data_s),
    .rd_data (rd_data_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // The result stage drains first, which frees the operand stage for the FIFO head
  assign s2_adv_s  = s1_valid_r && (!out_valid_r || io.out_ready);
  assign s1_free_s = !s1_valid_r || s2_adv_s;
  assign pop_s     = !empty_s && s1_free_s;

  // Operand stage and result stage; data registers are left alone on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      mul_a_r      <= {WIDTH{1'b0}};
      mul_b_r      <= {WIDTH{1'b0}};
      mul_rnd_r    <= 2'b00;
      out_valid_r  <= 1'b0;
      out_result_r <= {WIDTH{1'b0}};
    end else if (io.flush) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (pop_s) begin
        mul_a_r    <= head_a_s;
        mul_b_r    <= head_b_s;
        mul_rnd_r  <= head_rnd_s;
        s1_valid_r <= 1'b1;
      end else if (s1_free_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s2_adv_s) begin
        out_result_r <= io.mul_result;
        out_valid_r  <= 1'b1;
      end else if (out_valid_r && io.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign io.in_ready   = !full_s;
  assign io.fifo_count = count_s;
  assign io.mul_a      = mul_a_r;
  assign io.mul_b      = mul_b_r;
  assign io.mul_rnd    = mul_rnd_r;
  assign io.out_valid  = out_valid_r;
  assign io.out_result = out_result_r;

endmodule

// File: tb/tb_fp_mult_stream.sv
// Bench for fp_mult_stream: a normal-number multiplier stub plays the core,
// and a queue scoreboard checks every result handed to the consumer.
module tb_fp_mult_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mult_stream_if #(.WIDTH(32), .DEPTH(4)) io ();

  fp_mult_stream #(.WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  // Truncating multiply, exact for the operand pairs used here
  function automatic logic [31:0] fp_mul_stub(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  assign io.mul_result = fp_mul_stub(io.mul_a, io.mul_b);

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;

  // Advance one cycle; handshakes are observed at the falling edge before they commit
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (rst || io.flush) begin
      exp_q.delete();
    end else begin
      if (io.out_valid && io.out_ready) begin
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_result %h with nothing expected", io.out_result);
        end else begin
          e = exp_q.pop_front();
          if (io.out_result !== e) begin
            n_fail++;
            $display("FAIL sb_result: got %h want %h", io.out_result, e);
          end
        end
      end
      if (io.in_valid && io.in_ready) exp_q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.in_rnd   = 2'd0;
    cur_exp     = e;
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !io.out_valid) break;
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0 || io.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results still pending, out_valid %b", name, exp_q.size(), io.out_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (io.out_valid !== 1'b0 || io.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid %b fifo_count %0d want 0 0", io.out_valid, io.fifo_count);
    end
    n_checks++;
    if (io.mul_a !== 32'd0 || io.mul_b !== 32'd0 || io.mul_rnd !== 2'd0 || io.out_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: mul_a %h mul_b %h mul_rnd %0d out_result %h want all 0",
               io.mul_a, io.mul_b, io.mul_rnd, io.out_result);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (io.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", io.in_ready);
    end
  endtask

  task automatic test_single();
    drive(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
    tick();
    idle();
    n_checks++;
    if (io.fifo_count !== 3'd1 || io.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1: fifo_count %0d out_valid %b want 1 0", io.fifo_count, io.out_valid);
    end
    tick();
    n_checks++;
    if (io.fifo_count !== 3'd0 || io.out_valid !== 1'b0 || io.mul_a !== 32'h3F80_0000) begin
      n_fail++;
      $display("FAIL single_edge2: fifo_count %0d out_valid %b mul_a %h want 0 0 3f800000",
               io.fifo_count, io.out_valid, io.mul_a);
    end
    tick();
    n_checks++;
    if (io.out_valid !== 1'b1 || io.out_result !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL single_edge3: out_valid %b out_result %h want 1 40000000", io.out_valid, io.out_result);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    drive(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
    tick();
    drive(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    tick();
    idle();
    tick();
    n_checks++;
    if (io.out_valid !== 1'b1 || io.out_result !== 32'h40C0_0000) begin
      n_fail++;
      $display("FAIL b2b_first: out_valid %b out_result %h want 1 40c00000", io.out_valid, io.out_result);
    end
    tick();
    n_checks++;
    if (io.out_valid !== 1'b1 || io.out_result !== 32'h4010_0000) begin
      n_fail++;
      $display("FAIL b2b_second: out_valid %b out_result %h want 1 40100000", io.out_valid, io.out_result);
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    int          acc;
    int          out0;
    logic [31:0] held;
    logic [31:0] a;
    acc  = 0;
    out0 = n_out;
    io.out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      a = 32'h3F80_0000 + (32'(acc) << 20);
      drive(a, 32'h4000_0000, a + 32'h0080_0000);
      if (io.in_ready) acc++;
      tick();
    end
    idle();
    n_checks++;
    if (acc != 6 || io.in_ready !== 1'b0 || io.fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL bp_capacity: accepted %0d in_ready %b fifo_count %0d want 6 0 4",
               acc, io.in_ready, io.fifo_count);
    end
    held = io.out_result;
    repeat (3) tick();
    n_checks++;
    if (io.out_valid !== 1'b1 || io.out_result !== held || io.out_result !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL bp_hold: out_valid %b out_result %h want 1 40000000", io.out_valid, io.out_result);
    end
    io.out_ready = 1'b1;
    drain("bp");
    n_checks++;
    if (n_out - out0 != 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results want 6", n_out - out0);
    end
  endtask

  task automatic test_full_boundary();
    logic [31:0] a;
    int          out0;
    out0 = n_out;
    io.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = 32'h3F80_0000 + (32'(k + 1) << 20);
      drive(a, 32'h4000_0000, a + 32'h0080_0000);
      tick();
    end
    drive(32'h3FF0_0000, 32'h4000_0000, 32'h4070_0000);
    io.out_ready = 1'b1;
    n_checks++;
    if (io.in_ready !== 1'b0 || io.fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_pre: in_ready %b fifo_count %0d want 0 4", io.in_ready, io.fifo_count);
    end
    tick();
    idle();
    n_checks++;
    if (io.fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL full_pushpop: fifo_count %0d want 3", io.fifo_count);
    end
    drain("full");
    n_checks++;
    if (n_out - out0 != 6) begin
      n_fail++;
      $display("FAIL full_count: got %0d results want 6", n_out - out0);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    int          out0;
    io.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 32'h3F80_0000 + (32'(k + 2) << 20);
      drive(a, 32'h4000_0000, a + 32'h0080_0000);
      tick();
    end
    drive(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    io.flush = 1'b1;
    tick();
    io.flush = 1'b0;
    idle();
    n_checks++;
    if (io.out_valid !== 1'b0 || io.fifo_count !== 3'd0 || dut.s1_valid_r !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: out_valid %b fifo_count %0d s1_valid %b want 0 0 0",
               io.out_valid, io.fifo_count, dut.s1_valid_r);
    end
    io.out_ready = 1'b1;
    out0 = n_out;
    drive(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
    tick();
    idle();
    drain("flush");
    n_checks++;
    if (n_out - out0 != 1) begin
      n_fail++;
      $display("FAIL flush_after: got %0d results want 1", n_out - out0);
    end
  endtask

  task automatic test_async_reset();
    io.out_ready = 1'b0;
    drive(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    tick();
    drive(32'h3FE0_0000, 32'h4000_0000, 32'h4060_0000);
    tick();
    idle();
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (io.out_valid !== 1'b0 || io.fifo_count !== 3'd0 || dut.s1_valid_r !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: out_valid %b fifo_count %0d s1_valid %b want 0 0 0",
               io.out_valid, io.fifo_count, dut.s1_valid_r);
    end
    tick();
    rst = 1'b0;
    io.out_ready = 1'b1;
    n_checks++;
    if (io.in_ready !== 1'b1 || io.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_release: in_ready %b fifo_count %0d want 1 0", io.in_ready, io.fifo_count);
    end
    repeat (2) tick();
    n_checks++;
    if (io.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_no_output: out_valid %b want 0", io.out_valid);
    end
    drive(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    tick();
    idle();
    drain("areset");
  endtask

  initial begin
    rst          = 1'b1;
    io.flush     = 1'b0;
    io.in_valid  = 1'b0;
    io.in_a      = 32'd0;
    io.in_b      = 32'd0;
    io.in_rnd    = 2'd0;
    io.out_ready = 1'b1;
    cur_exp      = 32'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_boundary();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
